// File: rtl/cond_exec_unit_v2_if.sv
// Execute-stage conditional-unit bus: decoder controls and ALU flags in,
// condition-gated controls, per-lane enables, flags and IT status out.
interface cond_exec_unit_v2_if #(
  parameter int LANES = 1
);
  logic                 ValidE;
  logic                 StallE;
  logic                 FlushE;
  logic [3:0]           CondE;
  logic [4*LANES-1:0]   ALUFlags;
  logic [1:0]           FlagWriteE;
  logic                 PCSrcE_IN;
  logic                 RegWriteE_IN;
  logic                 MemWriteE_IN;
  logic                 BranchE;
  logic                 NoWrite;
  logic                 RegWSPU;
  logic                 ITStartE;
  logic [2:0]           ITLenE;
  logic [3:0]           ITThenE;
  logic                 PCSrcE_OUT;
  logic                 RegWriteE_OUT;
  logic                 MemWriteE_OUT;
  logic                 BranchTakenE;
  logic [LANES-1:0]     LaneEnE;
  logic [4*LANES-1:0]   flags;
  logic                 ITActive;
  logic [2:0]           ITRemaining;

  // No handshake: one instruction per cycle is presented while ValidE is high,
  // and StallE holds it in place without consuming it.
  modport master (
    output ValidE, StallE, FlushE, CondE, ALUFlags, FlagWriteE,
           PCSrcE_IN, RegWriteE_IN, MemWriteE_IN, BranchE, NoWrite, RegWSPU,
           ITStartE, ITLenE, ITThenE,
    input  PCSrcE_OUT, RegWriteE_OUT, MemWriteE_OUT, BranchTakenE,
           LaneEnE, flags, ITActive, ITRemaining
  );

  modport slave (
    input  ValidE, StallE, FlushE, CondE, ALUFlags, FlagWriteE,
           PCSrcE_IN, RegWriteE_IN, MemWriteE_IN, BranchE, NoWrite, RegWSPU,
           ITStartE, ITLenE, ITThenE,
    output PCSrcE_OUT, RegWriteE_OUT, MemWriteE_OUT, BranchTakenE,
           LaneEnE, flags, ITActive, ITRemaining
  );
endinterface

// File: rtl/cond_exec_unit_v2.sv
// Per-lane NZCV flag store and ARM condition evaluation with stall/flush.
// Optional IT-block sequencer enabled by defining COND_IT_BLOCK_EN.
module cond_exec_unit_v2 #(
  parameter int LANES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  cond_exec_unit_v2_if.slave    bus
);

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = cy;
      4'h3:    cond_pass = ~cy;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = cy & ~z;
      4'h9:    cond_pass = ~cy | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  logic [4*LANES-1:0] flags_q, flags_d;
  logic [LANES-1:0]   pass;
  logic [3:0]         eff_cond;
  logic               acc, live, cmd_en, it_instr;
  logic               pc_out, rw_out, mw_out, br_out;

`ifdef COND_IT_BLOCK_EN
  typedef enum logic {IT_IDLE, IT_ACTIVE} it_state_t;
  it_state_t   it_state_q, it_state_d;
  logic [3:0]  base_cond_q, base_cond_d;
  logic [3:0]  it_then_q, it_then_d;
  logic [2:0]  it_rem_q, it_rem_d;
  logic [1:0]  it_k_q, it_k_d;
  logic        it_legal;
`endif

  always_comb begin
    acc  = bus.ValidE & ~bus.StallE & ~bus.FlushE;
    live = bus.ValidE & ~bus.FlushE & ~reset;
`ifdef COND_IT_BLOCK_EN
    // Any IT encoding, legal or not, issues no commands of its own.
    it_instr = bus.ITStartE;
    it_legal = (bus.ITLenE >= 3'd1) && (bus.ITLenE <= 3'd4);
    if (it_state_q == IT_ACTIVE) begin
      if (it_then_q[it_k_q] || base_cond_q == 4'hE) eff_cond = base_cond_q;
      else                                          eff_cond = base_cond_q ^ 4'b0001;
    end else begin
      eff_cond = bus.CondE;
    end
`else
    it_instr = 1'b0;
    eff_cond = bus.CondE;
`endif
    pass = '0;
    for (int i = 0; i < LANES; i++) pass[i] = cond_pass(eff_cond, flags_q[4*i +: 4]);
    cmd_en = live & ~it_instr;
    pc_out = cmd_en & bus.PCSrcE_IN & pass[0];
    mw_out = cmd_en & bus.MemWriteE_IN & pass[0];
    br_out = cmd_en & bus.BranchE & pass[0];
    rw_out = cmd_en & ((bus.RegWriteE_IN & pass[0] & ~bus.NoWrite) | bus.RegWSPU);

    // Condition uses the old flags; new values appear next cycle.
    flags_d = flags_q;
    if (acc && !it_instr) begin
      for (int i = 0; i < LANES; i++) begin
        if (pass[i]) begin
          if (bus.FlagWriteE[1]) flags_d[4*i+2 +: 2] = bus.ALUFlags[4*i+2 +: 2];
          if (bus.FlagWriteE[0]) flags_d[4*i   +: 2] = bus.ALUFlags[4*i   +: 2];
        end
      end
    end

`ifdef COND_IT_BLOCK_EN
    it_state_d  = it_state_q;
    base_cond_d = base_cond_q;
    it_then_d   = it_then_q;
    it_rem_d    = it_rem_q;
    it_k_d      = it_k_q;
    if (bus.FlushE) begin
      it_state_d = IT_IDLE;
      it_rem_d   = 3'd0;
    end else if (acc) begin
      if (bus.ITStartE) begin
        if (it_legal) begin
          it_state_d  = IT_ACTIVE;
          base_cond_d = bus.CondE;
          it_then_d   = bus.ITThenE;
          it_rem_d    = bus.ITLenE;
          it_k_d      = 2'd0;
        end
      end else if (it_state_q == IT_ACTIVE) begin
        if (pc_out || br_out || it_rem_q == 3'd1) begin
          it_state_d = IT_IDLE;
          it_rem_d   = 3'd0;
        end else begin
          it_rem_d = it_rem_q - 3'd1;
          it_k_d   = it_k_q + 2'd1;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
`ifdef COND_IT_BLOCK_EN
      it_state_q  <= IT_IDLE;
      base_cond_q <= 4'h0;
      it_then_q   <= 4'h0;
      it_rem_q    <= 3'd0;
      it_k_q      <= 2'd0;
`endif
    end else begin
      flags_q <= flags_d;
`ifdef COND_IT_BLOCK_EN
      it_state_q  <= it_state_d;
      base_cond_q <= base_cond_d;
      it_then_q   <= it_then_d;
      it_rem_q    <= it_rem_d;
      it_k_q      <= it_k_d;
`endif
    end
  end

  assign bus.PCSrcE_OUT    = pc_out;
  assign bus.RegWriteE_OUT = rw_out;
  assign bus.MemWriteE_OUT = mw_out;
  assign bus.BranchTakenE  = br_out;
  assign bus.LaneEnE       = pass & {LANES{cmd_en}};
  assign bus.flags         = flags_q;

`ifdef COND_IT_BLOCK_EN
  assign bus.ITActive    = (it_state_q == IT_ACTIVE);
  assign bus.ITRemaining = it_rem_q;
`else
  logic unused_it;
  assign unused_it       = ^{bus.ITLenE, bus.ITThenE};
  assign bus.ITActive    = 1'b0;
  assign bus.ITRemaining = 3'd0;
`endif

endmodule

// File: tb/tb_cond_exec_unit_v2.sv
// Directed bench for cond_exec_unit_v2 with four lanes; the IT-block section
// follows whichever COND_IT_BLOCK_EN build is compiled.
module tb_cond_exec_unit_v2;
  localparam int LANES = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cond_exec_unit_v2_if #(.LANES(LANES)) bus ();
  cond_exec_unit_v2 #(.LANES(LANES)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    bus.ValidE = 1'b0; bus.StallE = 1'b0; bus.FlushE = 1'b0; bus.CondE = 4'hE;
    bus.ALUFlags = '0; bus.FlagWriteE = 2'b00; bus.PCSrcE_IN = 1'b0;
    bus.RegWriteE_IN = 1'b0; bus.MemWriteE_IN = 1'b0; bus.BranchE = 1'b0;
    bus.NoWrite = 1'b0; bus.RegWSPU = 1'b0; bus.ITStartE = 1'b0;
    bus.ITLenE = 3'd0; bus.ITThenE = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] cmd_outs();
    return {bus.PCSrcE_OUT, bus.RegWriteE_OUT, bus.MemWriteE_OUT, bus.BranchTakenE};
  endfunction

  logic [3:0] cond_tab [10];
  logic [3:0] lane_tab [10];

  initial begin
    // clock/reset: reset held with every command asserted
    idle_inputs();
    reset = 1'b1;
    bus.ValidE = 1'b1; bus.RegWriteE_IN = 1'b1; bus.MemWriteE_IN = 1'b1;
    bus.PCSrcE_IN = 1'b1; bus.BranchE = 1'b1;
    #1;
    check("reset_cmds", cmd_outs(), 4'h0);
    check("reset_lane_en", bus.LaneEnE, 4'h0);
    check("reset_flags", bus.flags, 16'h0000);
    check("reset_it_active", bus.ITActive, 1'b0);
    check("reset_it_rem", bus.ITRemaining, 3'd0);
    tick(); tick();
    reset = 1'b0;
    idle_inputs();
    tick();

    // write NZ on every lane, only lane3 gets Z
    bus.ValidE = 1'b1; bus.CondE = 4'hE; bus.ALUFlags = 16'h4000; bus.FlagWriteE = 2'b10;
    #1 check("al_lane_en", bus.LaneEnE, 4'hF);
    tick();
    check("flags_lane3_z", bus.flags, 16'h4000);

    // EQ passes only lane3; its flag write uses the old Z
    bus.CondE = 4'h0; bus.ALUFlags = 16'h8888; bus.RegWriteE_IN = 1'b1;
    #1 check("eq_lane_en", bus.LaneEnE, 4'b1000);
    check("eq_lane0_fail_rw", bus.RegWriteE_OUT, 1'b0);
    tick();
    check("eq_masked_write", bus.flags, 16'h8000);

    bus.CondE = 4'hE; bus.ALUFlags = 16'h4444; bus.RegWriteE_IN = 1'b0;
    tick();
    check("flags_all_z", bus.flags, 16'h4444);

    // scalar gating with lane0 Z=1
    bus.FlagWriteE = 2'b00; bus.CondE = 4'h0; bus.RegWriteE_IN = 1'b1;
    bus.MemWriteE_IN = 1'b1; bus.PCSrcE_IN = 1'b1; bus.BranchE = 1'b1;
    #1 check("eq_pass_cmds", cmd_outs(), 4'hF);
    bus.NoWrite = 1'b1;
    #1 check("nowrite_rw", bus.RegWriteE_OUT, 1'b0);
    bus.RegWSPU = 1'b1;
    #1 check("regwspu_rw", bus.RegWriteE_OUT, 1'b1);
    bus.NoWrite = 1'b0; bus.RegWSPU = 1'b0; bus.CondE = 4'h1;
    #1 check("ne_fail_cmds", cmd_outs(), 4'h0);
    bus.ValidE = 1'b0; bus.CondE = 4'hE; bus.RegWSPU = 1'b1;
    #1 check("invalid_cmds", cmd_outs(), 4'h0);
    check("invalid_lane_en", bus.LaneEnE, 4'h0);
    idle_inputs();

    // stall: outputs live, flags hold
    bus.ValidE = 1'b1; bus.StallE = 1'b1; bus.CondE = 4'hE; bus.RegWriteE_IN = 1'b1;
    bus.FlagWriteE = 2'b11; bus.ALUFlags = 16'hFFFF;
    #1 check("stall_rw", bus.RegWriteE_OUT, 1'b1);
    tick();
    check("stall_flags_hold", bus.flags, 16'h4444);
    bus.StallE = 1'b0; bus.FlushE = 1'b1; bus.MemWriteE_IN = 1'b1;
    #1 check("flush_cmds", cmd_outs(), 4'h0);
    check("flush_lane_en", bus.LaneEnE, 4'h0);
    tick();
    check("flush_flags_hold", bus.flags, 16'h4444);
    idle_inputs();

    // mixed flags for a condition sweep
    bus.ValidE = 1'b1; bus.CondE = 4'hE; bus.FlagWriteE = 2'b11; bus.ALUFlags = 16'h935A;
    tick();
    check("flags_mixed", bus.flags, 16'h935A);
    bus.FlagWriteE = 2'b00;
    cond_tab = '{4'hA, 4'hB, 4'h8, 4'h9, 4'hC, 4'hD, 4'h4, 4'h6, 4'h2, 4'hF};
    lane_tab = '{4'b1000, 4'b0111, 4'b0101, 4'b1010, 4'b1000,
                 4'b0111, 4'b1001, 4'b1110, 4'b0101, 4'b0000};
    for (int i = 0; i < 10; i++) begin
      bus.CondE = cond_tab[i];
      #1 check($sformatf("cond_%0h_lanes", cond_tab[i]), bus.LaneEnE, lane_tab[i]);
    end

    // reset mid-run with live flags
    bus.CondE = 4'hE; bus.RegWriteE_IN = 1'b1;
    #1 check("pre_reset_rw", bus.RegWriteE_OUT, 1'b1);
    reset = 1'b1;
    #1 check("mid_reset_flags", bus.flags, 16'h0000);
    check("mid_reset_cmds", cmd_outs(), 4'h0);
    check("mid_reset_it_active", bus.ITActive, 1'b0);
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();

`ifdef COND_IT_BLOCK_EN
    bus.ValidE = 1'b1; bus.CondE = 4'hE; bus.FlagWriteE = 2'b10; bus.ALUFlags = 16'h0004;
    tick();
    bus.FlagWriteE = 2'b00; bus.ALUFlags = '0;
    bus.ITStartE = 1'b1; bus.ITLenE = 3'd3; bus.ITThenE = 4'b0101;
    bus.CondE = 4'h0; bus.MemWriteE_IN = 1'b1;
    #1 check("it_instr_mw", bus.MemWriteE_OUT, 1'b0);
    tick();
    check("it_active", bus.ITActive, 1'b1);
    bus.ITStartE = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1 check($sformatf("it_rem_%0d", j), bus.ITRemaining, 3'(3 - j));
      check($sformatf("it_mw_%0d", j), bus.MemWriteE_OUT, (j == 1) ? 1'b0 : 1'b1);
      tick();
    end
    check("it_done_rem", bus.ITRemaining, 3'd0);
    check("it_done_active", bus.ITActive, 1'b0);

    bus.MemWriteE_IN = 1'b0; bus.ITStartE = 1'b1; bus.ITLenE = 3'd4;
    bus.ITThenE = 4'hF; bus.CondE = 4'hE;
    tick();
    bus.ITStartE = 1'b0;
    tick();
    check("it4_rem_after1", bus.ITRemaining, 3'd3);
    bus.BranchE = 1'b1;
    #1 check("it4_branch_taken", bus.BranchTakenE, 1'b1);
    tick();
    check("it4_early_exit", bus.ITActive, 1'b0);
    bus.BranchE = 1'b0; bus.ITStartE = 1'b1; bus.ITLenE = 3'd0; bus.MemWriteE_IN = 1'b1;
    #1 check("itlen0_nop_mw", bus.MemWriteE_OUT, 1'b0);
    tick();
    check("itlen0_idle", bus.ITActive, 1'b0);
`else
    bus.ValidE = 1'b1; bus.ITStartE = 1'b1; bus.ITLenE = 3'd3; bus.ITThenE = 4'b0101;
    bus.CondE = 4'hE; bus.RegWriteE_IN = 1'b1;
    #1 check("it_ignored_rw", bus.RegWriteE_OUT, 1'b1);
    tick();
    check("it_ignored_active", bus.ITActive, 1'b0);
    check("it_ignored_rem", bus.ITRemaining, 3'd0);
`endif
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
